// File: rtl/cv32e40p_mult_iter.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40p_mult_iter
// Brief   : Iterative WIDTHxWIDTH multiplier that consumes one SLICE-bit digit
//           of op_b per cycle and returns the MUL/MULH/MULHSU/MULHU half
// Revision: 1.0
// ============================================================================
module cv32e40p_mult_iter #(
  parameter int WIDTH     = 32,
  parameter int SLICE     = 8,
  parameter int ZERO_SKIP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_a_signed;
  logic             r_b_signed;
  logic             r_mul_low;

  logic             w_accept;
  logic             w_zero;
  logic [SLICE-1:0] w_digit;
  logic             w_digit_sign;
  logic [PW-1:0]    w_a_wide;
  logic [PW-1:0]    w_d_wide;
  logic [PW-1:0]    w_pp;
  logic [31:0]      w_shamt;
  logic [PW-1:0]    w_acc_next;

  assign ready_o  = (r_state == c_IDLE) | ((r_state == c_DONE) & (ready_i | kill_i));
  assign w_accept = valid_i & ready_o & ~kill_i;
  assign w_zero   = (ZERO_SKIP != 0) & ((op_a_i == '0) | (op_b_i == '0));

  always_comb begin
    w_digit = '0;
    for (int k = 0; k < N; k++) begin
      if (r_cnt == CNT_W'(k)) begin
        w_digit = r_op_b[k*SLICE +: SLICE];
      end
    end
  end

  // Only the most significant digit of a signed B carries negative weight;
  // both factors are sign-extended to 2*WIDTH so the product wraps correctly.
  assign w_digit_sign = r_b_signed & (r_cnt == c_LAST) & w_digit[SLICE-1];
  assign w_a_wide     = {{WIDTH{r_a_signed & r_op_a[WIDTH-1]}}, r_op_a};
  assign w_d_wide     = {{(PW-SLICE){w_digit_sign}}, w_digit};
  assign w_pp         = w_a_wide * w_d_wide;
  assign w_shamt      = 32'(r_cnt) * 32'(SLICE);
  assign w_acc_next   = r_acc + (w_pp << w_shamt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_a_signed <= 1'b0;
      r_b_signed <= 1'b0;
      r_mul_low  <= 1'b0;
    end else if (kill_i) begin
      r_state <= c_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (w_accept) begin
            r_op_a     <= op_a_i;
            r_op_b     <= op_b_i;
            r_a_signed <= (operator_i == 2'b01) | (operator_i == 2'b10);
            r_b_signed <= (operator_i == 2'b01);
            r_mul_low  <= (operator_i == 2'b00);
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= w_zero ? c_DONE : c_BUSY;
          end else if ((r_state == c_DONE) && ready_i) begin
            r_state <= c_IDLE;
          end
        end
        c_BUSY: begin
          r_acc <= w_acc_next;
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_state <= c_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign valid_o  = (r_state == c_DONE);
  assign busy_o   = (r_state != c_IDLE);
  // Partial accumulator contents stay hidden until the product is complete.
  assign result_o = valid_o ? (r_mul_low ? r_acc[WIDTH-1:0] : r_acc[PW-1:WIDTH]) : '0;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_mult_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cv32e40p_mult_iter
// Brief   : Directed-vector and randomised bench for cv32e40p_mult_iter
// Revision: 1.0
// ============================================================================
module tb_cv32e40p_mult_iter;

  localparam int NI = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] valid_v;
  logic [1:0]    op;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          kill;
  logic          rdy_i;
  logic [NI-1:0] rdy_o;
  logic [NI-1:0] vld_o;
  logic [NI-1:0] bsy_o;
  logic [31:0]   res_o [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instances: 0 S8, 1 S8 without zero-skip, 2 S1, 3 S4, 4 S16, 5 S32
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int SL = (g <= 1) ? 8 : (g == 2) ? 1 : (g == 3) ? 4 : (g == 4) ? 16 : 32;
    localparam int ZS = (g == 1) ? 0 : 1;
    cv32e40p_mult_iter #(.WIDTH(32), .SLICE(SL), .ZERO_SKIP(ZS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (valid_v[g]),
      .ready_o   (rdy_o[g]),
      .operator_i(op),
      .op_a_i    (a),
      .op_b_i    (b),
      .kill_i    (kill),
      .valid_o   (vld_o[g]),
      .ready_i   (rdy_i),
      .result_o  (res_o[g]),
      .busy_o    (bsy_o[g])
    );
  end

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic int n_of(input int s);
    case (s)
      0, 1:    return 4;
      2:       return 32;
      3:       return 8;
      4:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ax;
    logic [63:0] by;
    logic [63:0] p;
    ax = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    by = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p  = ax * by;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic start_op(input int s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
    valid_v    = '0;
    valid_v[s] = 1'b1;
    #1;
    chk("ready_o before accept", 32'(rdy_o[s]), 32'd1);
    @(posedge clk);
    #1;
    valid_v = '0;
  endtask

  task automatic wait_done(input int s, output int lat);
    lat = 0;
    while (!vld_o[s] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!vld_o[s]) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for valid_o on instance %0d: got 0 expected 1", s);
    end
  endtask

  task automatic run(input string name, input int s, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(s, o, x, y);
    wait_done(s, lat);
    chk({name, " result"}, res_o[s], exp);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic drain();
    rdy_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int seen;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          rlat;

    rst_n   = 1'b0;
    valid_v = '0;
    op      = 2'b00;
    a       = '0;
    b       = '0;
    kill    = 1'b0;
    rdy_i   = 1'b1;

    vecs.push_back('{0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4});
    vecs.push_back('{0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4});
    vecs.push_back('{0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4});
    vecs.push_back('{0, 2'b00, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 4});
    vecs.push_back('{0, 2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 0});
    vecs.push_back('{1, 2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 4});
    vecs.push_back('{0, 2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 4});
    vecs.push_back('{0, 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 4});
    vecs.push_back('{0, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 4});
    vecs.push_back('{2, 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32});
    vecs.push_back('{3, 2'b11, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 8});
    vecs.push_back('{4, 2'b01, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 2});
    vecs.push_back('{5, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1});
    vecs.push_back('{5, 2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 1});
    vecs.push_back('{0, 2'b11, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset ready_o", 32'(rdy_o[0]), 32'd1);
    chk("reset valid_o", 32'(vld_o[0]), 32'd0);
    chk("reset busy_o", 32'(bsy_o[0]), 32'd0);
    chk("reset result_o", res_o[0], 32'd0);

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b,
          vecs[i].exp, vecs[i].lat);
    end

    // Backpressure, then a back-to-back accept in the releasing cycle
    drain();
    rdy_i = 1'b0;
    run("bp first", 0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp result held", res_o[0], 32'h4000_0000);
      chk("bp valid held", 32'(vld_o[0]), 32'd1);
      chk("bp ready_o low", 32'(rdy_o[0]), 32'd0);
    end
    rdy_i = 1'b1;
    start_op(0, 2'b11, 32'h2, 32'h3);
    chk("b2b busy after accept", 32'(bsy_o[0]), 32'd1);
    chk("b2b valid dropped", 32'(vld_o[0]), 32'd0);
    wait_done(0, lat);
    chk("b2b result", res_o[0], 32'h0);
    chk("b2b latency", 32'(lat), 32'd4);

    // Kill at iteration 2 with a competing request
    start_op(0, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    kill       = 1'b1;
    op         = 2'b00;
    a          = 32'd5;
    b          = 32'd5;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    kill    = 1'b0;
    valid_v = '0;
    chk("kill busy cleared", 32'(bsy_o[0]), 32'd0);
    chk("kill ready_o idle", 32'(rdy_o[0]), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (vld_o[0] || bsy_o[0]) seen++;
    end
    chk("kill no later activity", 32'(seen), 32'd0);
    run("post-kill mul", 0, 2'b00, 32'd7, 32'd6, 32'd42, 4);

    // Kill in DONE while the consumer is ready
    drain();
    rdy_i = 1'b0;
    run("killdone op", 0, 2'b01, 32'h0000_0100, 32'h0100_0000, 32'h0000_0001, 4);
    rdy_i      = 1'b1;
    kill       = 1'b1;
    op         = 2'b00;
    a          = 32'd3;
    b          = 32'd3;
    valid_v[0] = 1'b1;
    @(posedge clk);
    #1;
    kill    = 1'b0;
    valid_v = '0;
    chk("killdone valid dropped", 32'(vld_o[0]), 32'd0);
    chk("killdone not accepted", 32'(bsy_o[0]), 32'd0);

    // Asynchronous reset in the middle of a long operation
    drain();
    start_op(2, 2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset busy", 32'(bsy_o[2]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ready_o", 32'(rdy_o[2]), 32'd1);
    chk("async reset valid_o", 32'(vld_o[2]), 32'd0);
    chk("async reset busy_o", 32'(bsy_o[2]), 32'd0);
    chk("async reset result_o", res_o[2], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random sweep against a 64-bit reference product
    for (int s = 0; s < NI; s++) begin
      for (int i = 0; i < ((s == 2) ? 200 : 600); i++) begin
        ro   = 2'($urandom_range(0, 3));
        rx   = rnd_operand();
        ry   = rnd_operand();
        rlat = (s != 1 && (rx == 0 || ry == 0)) ? 0 : n_of(s);
        run($sformatf("rnd s%0d op%0d %08h*%08h", s, ro, rx, ry), s, ro, rx, ry,
            ref_mul(ro, rx, ry), rlat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
